perceptron_trainer: RTL and testbench

- Delta-rule learning stage sitting beside the two-input perceptron core.
- Consumes the neuron's current inputs, result and weights plus a target value.
- Computes w_i <= w_i + (target - result) * x_i * 2^-LR_SHIFT sequentially on one shared multiplier.
- Drives the core's weight-load strobe. The communication controller issues start and collects done.

---
 rtl/perceptron_trainer.sv | 142 ++++++++++++++
 tb/tb_perceptron_trainer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - delta-rule weight update for the two-input perceptron (optional PERCEPTRON_TRAINER_SAT_EN)
module perceptron_trainer #(
    parameter int fp_integer_width = 4,
    parameter int fp_fract_width   = 12,
    parameter int LR_SHIFT         = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [fp_integer_width+fp_fract_width-1:0] target,
    input  logic [fp_integer_width+fp_fract_width-1:0] in1,
    input  logic [fp_integer_width+fp_fract_width-1:0] in2,
    input  logic [fp_integer_width+fp_fract_width-1:0] result,
    input  logic [fp_integer_width+fp_fract_width-1:0] weight1_curr,
    input  logic [fp_integer_width+fp_fract_width-1:0] weight2_curr,
    input  logic                                     clear_count,
    output logic [fp_integer_width+fp_fract_width-1:0] weight1_new,
    output logic [fp_integer_width+fp_fract_width-1:0] weight2_new,
    output logic                                     weight_ld,
    output logic                                     busy,
    output logic                                     done,
    output logic [15:0]                              update_count
);
    localparam int W  = fp_integer_width + fp_fract_width;
    localparam int SH = fp_fract_width + LR_SHIFT;

    typedef enum logic [2:0] {IDLE, ERR, MUL1, MUL2, WRITE} state_t;
    state_t state, state_nx;

    logic [W-1:0] tgt_q, res_q, x1_q, x2_q, w1_q, w2_q;
    logic [W-1:0] err_q, sum1_q, sum2_q;
    logic         done_q, ld_q;

    logic signed [W:0]     err_full;
    logic [W-1:0]          err_red;
    logic [W-1:0]          x_mux, w_mux;
    logic signed [2*W-1:0] prod;
    logic [W-1:0]          sum_red;

    assign err_full = $signed({tgt_q[W-1], tgt_q}) - $signed({res_q[W-1], res_q});
    // A single multiplier serves both weights; the state picks the operand pair.
    assign x_mux = (state == MUL2) ? x2_q : x1_q;
    assign w_mux = (state == MUL2) ? w2_q : w1_q;
    assign prod  = $signed(err_q) * $signed(x_mux);

`ifdef PERCEPTRON_TRAINER_SAT_EN
    localparam logic signed [2*W-1:0] MAXV = (2*W)'((2**(W-1)) - 1);
    localparam logic signed [2*W-1:0] MINV = -(2*W)'(2**(W-1));

    function automatic logic [W-1:0] sat_w(input logic signed [2*W-1:0] v);
        if (v > MAXV)      return {1'b0, {(W-1){1'b1}}};
        else if (v < MINV) return {1'b1, {(W-1){1'b0}}};
        else               return v[W-1:0];
    endfunction

    logic signed [2*W-1:0] prod_sh;
    logic [W-1:0]          p_sat;
    logic signed [2*W-1:0] sum_full;

    assign err_red  = sat_w({{(W-1){err_full[W]}}, err_full});
    assign prod_sh  = prod >>> SH;
    assign p_sat    = sat_w(prod_sh);
    assign sum_full = $signed({{W{w_mux[W-1]}}, w_mux}) + $signed({{W{p_sat[W-1]}}, p_sat});
    assign sum_red  = sat_w(sum_full);
`else
    logic unused_bits;
    // Low W bits of (prod >>> SH) are exactly prod[SH +: W]; the rest wraps away.
    assign err_red     = err_full[W-1:0];
    assign sum_red     = w_mux + prod[SH +: W];
    assign unused_bits = ^{err_full[W], prod[2*W-1:SH+W], prod[SH-1:0]};
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ERR;
            ERR:     state_nx = MUL1;
            MUL1:    state_nx = MUL2;
            MUL2:    state_nx = WRITE;
            WRITE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tgt_q        <= '0;
            res_q        <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            w1_q         <= '0;
            w2_q         <= '0;
            err_q        <= '0;
            sum1_q       <= '0;
            sum2_q       <= '0;
            done_q       <= 1'b0;
            ld_q         <= 1'b0;
            weight1_new  <= '0;
            weight2_new  <= '0;
            update_count <= '0;
        end else begin
            state  <= state_nx;
            done_q <= 1'b0;
            ld_q   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    tgt_q <= target;
                    res_q <= result;
                    x1_q  <= in1;
                    x2_q  <= in2;
                    w1_q  <= weight1_curr;
                    w2_q  <= weight2_curr;
                end
                ERR:  err_q  <= err_red;
                MUL1: sum1_q <= sum_red;
                MUL2: sum2_q <= sum_red;
                WRITE: begin
                    done_q <= 1'b1;
                    if (err_q != '0) begin
                        ld_q        <= 1'b1;
                        weight1_new <= sum1_q;
                        weight2_new <= sum2_q;
                    end else begin
                        weight1_new <= w1_q;
                        weight2_new <= w2_q;
                    end
                end
                default: ;
            endcase
            if (clear_count)
                update_count <= '0;
            else if (state == WRITE && err_q != '0)
                update_count <= update_count + 16'd1;
        end
    end

    // Strobes are registered, so the step stays busy through the strobe cycle.
    assign weight_ld = ld_q;
    assign done      = done_q;
    assign busy      = (state != IDLE) || done_q;
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - randomized model-checked bench for perceptron_trainer
module tb_perceptron_trainer;
    logic        clk = 1'b0;
    logic        rst, start, clear_count;
    logic [15:0] target, in1, in2, result, weight1_curr, weight2_curr;
    logic [15:0] weight1_new, weight2_new, update_count;
    logic        weight_ld, busy, done;

    int errors = 0;
    int checks = 0;

    perceptron_trainer dut (
        .clk(clk), .rst(rst), .start(start), .target(target), .in1(in1), .in2(in2),
        .result(result), .weight1_curr(weight1_curr), .weight2_curr(weight2_curr),
        .clear_count(clear_count), .weight1_new(weight1_new), .weight2_new(weight2_new),
        .weight_ld(weight_ld), .busy(busy), .done(done), .update_count(update_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int red(input longint v);
        longint m;
`ifdef PERCEPTRON_TRAINER_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
`else
        m = v & 64'hFFFF;
        if (m >= 32768) m = m - 65536;
        return int'(m);
`endif
    endfunction

    function automatic int sx(input logic [15:0] a);
        return int'($signed(a));
    endfunction

    function automatic int err_of(input int t, input int r);
        return red(longint'(t) - longint'(r));
    endfunction

    function automatic int new_w(input int w, input int e, input int x);
        longint p;
        p = (longint'(e) * longint'(x)) >>> 14;
`ifdef PERCEPTRON_TRAINER_SAT_EN
        p = longint'(red(p));
`endif
        return red(longint'(w) + p);
    endfunction

    // Behavioural model: a step occupies five cycles after acceptance, strobe on the fifth.
    int          m_busy_left = 0;
    int          m_err = 0;
    logic [15:0] m_s1, m_s2, m_cw1, m_cw2;
    logic [15:0] m_w1 = 0, m_w2 = 0, m_cnt = 0;
    logic        exp_done = 0, exp_ld = 0;
    int          tmp;

    always @(posedge clk) begin
        if (rst) begin
            m_busy_left = 0; m_w1 = 0; m_w2 = 0; m_cnt = 0; exp_done = 0; exp_ld = 0;
        end else begin
            exp_done = 0;
            exp_ld   = 0;
            if (m_busy_left == 2) begin
                exp_done = 1;
                exp_ld   = (m_err != 0);
                m_w1 = exp_ld ? m_s1 : m_cw1;
                m_w2 = exp_ld ? m_s2 : m_cw2;
            end
            if (clear_count) m_cnt = 0;
            else if (m_busy_left == 2 && m_err != 0) m_cnt = m_cnt + 16'd1;
            if (m_busy_left > 0) m_busy_left--;
            if (m_busy_left == 0 && start) begin
                m_err = err_of(sx(target), sx(result));
                tmp   = new_w(sx(weight1_curr), m_err, sx(in1)); m_s1 = tmp[15:0];
                tmp   = new_w(sx(weight2_curr), m_err, sx(in2)); m_s2 = tmp[15:0];
                m_cw1 = weight1_curr;
                m_cw2 = weight2_curr;
                m_busy_left = 5;
            end
        end
    end

    logic cmp_en = 0;
    int   n_done = 0, n_ld = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy_left > 0});
            chk("done", {31'd0, done}, {31'd0, exp_done});
            chk("weight_ld", {31'd0, weight_ld}, {31'd0, exp_ld});
            chk("weight1_new", {16'd0, weight1_new}, {16'd0, m_w1});
            chk("weight2_new", {16'd0, weight2_new}, {16'd0, m_w2});
            chk("update_count", {16'd0, update_count}, {16'd0, m_cnt});
            if (done) n_done++;
            if (weight_ld) n_ld++;
        end
    end

    task automatic scramble();
        target = 16'($urandom); result = 16'($urandom); in1 = 16'($urandom);
        in2 = 16'($urandom); weight1_curr = 16'($urandom); weight2_curr = 16'($urandom);
    endtask

    task automatic step(input logic [15:0] t, input logic [15:0] r, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] w1, input logic [15:0] w2,
                        input logic clr);
        int guard;
        guard = 0;
        while (m_busy_left != 0 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 20) chk("idle_wait_timeout", 32'd1, 32'd0);
        target = t; result = r; in1 = a; in2 = b; weight1_curr = w1; weight2_curr = w2;
        clear_count = clr;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        repeat (5) @(posedge clk);
        #1;
        clear_count = 1'b0;
    endtask

    int d0, l0;

    initial begin
        rst = 1; start = 0; clear_count = 0;
        target = 0; result = 0; in1 = 0; in2 = 0; weight1_curr = 0; weight2_curr = 0;
        @(posedge clk); #1;
        cmp_en = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_count", {16'd0, update_count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        chk("pin_basic_w1", new_w(0, 4096, 4096), 32'h400);
        chk("pin_basic_w2", new_w(0, 4096, 2048), 32'h200);
        chk("pin_neg_w1", new_w(1024, -4096, 4096), 32'd0);
        chk("pin_neg_w2", new_w(0, -4096, -4096), 32'h400);

        d0 = n_done; l0 = n_ld;
        step(16'h1000, 16'h0000, 16'h1000, 16'h0800, 16'h0000, 16'h0000, 1'b0);
        chk("basic_w1", {16'd0, weight1_new}, 32'h0400);
        chk("basic_w2", {16'd0, weight2_new}, 32'h0200);
        chk("basic_count", {16'd0, update_count}, 32'd1);
        chk("basic_pulses", n_done - d0 + 10 * (n_ld - l0), 32'd11);

        d0 = n_done; l0 = n_ld;
        step(16'h0C00, 16'h0C00, 16'h1234, 16'h4321, 16'h0123, 16'h0456, 1'b0);
        chk("zero_w1", {16'd0, weight1_new}, 32'h0123);
        chk("zero_w2", {16'd0, weight2_new}, 32'h0456);
        chk("zero_count", {16'd0, update_count}, 32'd1);
        chk("zero_pulses", n_done - d0 + 10 * (n_ld - l0), 32'd1);

        step(16'h0000, 16'h1000, 16'h1000, 16'hF000, 16'h0400, 16'h0000, 1'b0);
        chk("neg_w1", {16'd0, weight1_new}, 32'h0000);
        chk("neg_w2", {16'd0, weight2_new}, 32'h0400);
        chk("neg_count", {16'd0, update_count}, 32'd2);

        step(16'h7FFF, 16'h8000, 16'h7000, 16'h0000, 16'h7000, 16'h0000, 1'b0);
`ifdef PERCEPTRON_TRAINER_SAT_EN
        chk("sat_w1", {16'd0, weight1_new}, 32'h7FFF);
`else
        chk("wrap_w1", {16'd0, weight1_new}, 32'h6FFE);
`endif

        // Start held for ten edges: accepted at N and N+5 only.
        d0 = n_done;
        target = 16'h0800; result = 16'h0000; in1 = 16'h1000; in2 = 16'h1000;
        weight1_curr = 16'h0000; weight2_curr = 16'h0000;
        start = 1;
        repeat (10) @(posedge clk);
        #1 start = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("held_start_steps", n_done - d0, 32'd2);

        // Reset while in MUL1 aborts the step.
        l0 = n_ld;
        target = 16'h1000; result = 16'h0000; start = 1;
        @(posedge clk); #1 start = 0;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_mid_ld", n_ld - l0, 32'd0);
        chk("rst_mid_count", {16'd0, update_count}, 32'd0);
        chk("rst_mid_w1", {16'd0, weight1_new}, 32'd0);

        step(16'h1000, 16'h0000, 16'h1000, 16'h1000, 16'h0000, 16'h0000, 1'b0);
        l0 = n_ld;
        step(16'h1000, 16'h0000, 16'h1000, 16'h1000, 16'h0000, 16'h0000, 1'b1);
        chk("clear_count_wins", {16'd0, update_count}, 32'd0);
        chk("clear_step_ld", n_ld - l0, 32'd1);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(3) == 0)
                step(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                     16'($urandom), 16'($urandom), 1'b0);
            else
                step(16'($urandom_range(16'h2000)), 16'($urandom_range(16'h2000)),
                     16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                     1'($urandom_range(9) == 0));
        end

        for (int i = 0; i < 400; i++) begin
            start = 1'($urandom_range(2) == 0);
            clear_count = 1'($urandom_range(15) == 0);
            scramble();
            if ($urandom_range(4) == 0) result = target;
            @(posedge clk); #1;
        end
        start = 0; clear_count = 0;
        repeat (8) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
